// File: rtl/udl_count_sequencer_pkg.sv
// Shared op codes and controller state encodings for the up/down/load counter sequencer.
package udl_count_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_UP   = 3'd2,
    ST_DOWN = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/udl_count_sequencer_counter.sv
// N-bit up/down counter with synchronous parallel load; load wins over counting.
module udl_counter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_enable,
  input  logic         i_up,
  input  logic         i_load,
  input  logic [N-1:0] i_l,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (i_enable) begin
      if (i_load)    r_q <= i_l;
      else if (i_up) r_q <= r_q + 1'b1;
      else           r_q <= r_q - 1'b1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/udl_count_sequencer.sv
// Command-driven sequencer for a W-bit counter: LOAD, count UP_TO/DOWN_TO a target, NOP.
// One count per cycle; completion, wrap and abort status reported with a one-cycle done pulse.
module udl_count_sequencer
  import udl_count_sequencer_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_data,
  input  logic         abort,
  output logic         busy,
  output logic         done,
  output logic         done_wrapped,
  output logic         done_aborted,
  output logic [W-1:0] q
);

  state_e       r_state;
  state_e       w_next;
  logic [W-1:0] r_tgt;
  logic         r_wrap;
  logic         r_abort;

  logic         w_accept;
  logic         w_en;
  logic         w_up;
  logic         w_load;
  logic         w_set_wrap;
  logic         w_set_abort;
  logic [W-1:0] w_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_tgt   <= '0;
      r_wrap  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_tgt   <= cmd_data;
        r_wrap  <= 1'b0;
        r_abort <= 1'b0;
      end else begin
        if (w_set_wrap)  r_wrap  <= 1'b1;
        if (w_set_abort) r_abort <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_en        = 1'b0;
    w_up        = 1'b0;
    w_load      = 1'b0;
    w_set_wrap  = 1'b0;
    w_set_abort = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_accept = 1'b1;
          case (cmd_op)
            OP_LOAD: w_next = ST_LOAD;
            OP_UP:   w_next = ST_UP;
            OP_DOWN: w_next = ST_DOWN;
            default: w_next = ST_DONE;
          endcase
        end
      end
      ST_LOAD: begin
        w_en   = 1'b1;
        w_load = 1'b1;
        w_next = ST_DONE;
      end
      // Abort is checked before the target compare so a coincident abort is reported.
      ST_UP: begin
        if (abort) begin
          w_set_abort = 1'b1;
          w_next      = ST_DONE;
        end else if (w_q == r_tgt) begin
          w_next = ST_DONE;
        end else begin
          w_en       = 1'b1;
          w_up       = 1'b1;
          w_set_wrap = (w_q == {W{1'b1}});
        end
      end
      ST_DOWN: begin
        if (abort) begin
          w_set_abort = 1'b1;
          w_next      = ST_DONE;
        end else if (w_q == r_tgt) begin
          w_next = ST_DONE;
        end else begin
          w_en       = 1'b1;
          w_set_wrap = (w_q == '0);
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  udl_counter #(.N(W)) u_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_enable (w_en),
    .i_up     (w_up),
    .i_load   (w_load),
    .i_l      (r_tgt),
    .o_q      (w_q)
  );

  assign q            = w_q;
  assign cmd_ready    = (r_state == ST_IDLE);
  assign busy         = (r_state != ST_IDLE);
  assign done         = (r_state == ST_DONE);
  assign done_wrapped = done & r_wrap;
  assign done_aborted = done & r_abort;

endmodule

// File: tb/tb_udl_count_sequencer.sv
// Self-checking bench: directed spec scenarios plus randomized commands against an arithmetic model.
module tb_udl_count_sequencer;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk;
  logic         reset_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         abort;
  logic         busy;
  logic         done;
  logic         done_wrapped;
  logic         done_aborted;
  logic [W-1:0] q;

  int n_checks = 0;
  int n_fail   = 0;
  int mq       = 0;

  udl_count_sequencer #(.W(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .done_wrapped (done_wrapped),
    .done_aborted (done_aborted),
    .q            (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one command from IDLE and follows it cycle by cycle. abort_at is the
  // 1-based cycle after acceptance in which abort is raised (0 = never).
  // With hold set, cmd_valid stays high and the task returns in the done cycle.
  task automatic run_cmd(input logic [1:0] op, input int data, input int abort_at,
                         input logic hold, input logic [W-1:0] hold_data);
    int q0, d, steps, exp_cyc, exp_q, fin_q, cyc;
    logic exp_wrap, exp_abort, got;
    q0 = mq; steps = 0; exp_wrap = 0; exp_abort = 0; fin_q = q0;
    case (op)
      2'b00: begin exp_cyc = 2; fin_q = data; end
      2'b01, 2'b10: begin
        d = (op == 2'b01) ? (data - q0 + M) % M : (q0 - data + M) % M;
        if (abort_at >= 1 && abort_at <= d + 1) begin
          steps = abort_at - 1; exp_abort = 1; exp_cyc = abort_at + 1;
        end else begin
          steps = d; exp_cyc = d + 2;
        end
        fin_q    = (op == 2'b01) ? (q0 + steps) % M : (q0 - steps + M) % M;
        exp_wrap = (op == 2'b01) ? (q0 + steps > M - 1) : (steps > q0);
      end
      default: exp_cyc = 1;
    endcase
    cmd_valid = 1'b1; cmd_op = op; cmd_data = W'(data);
    @(posedge clk); #1;
    if (hold) begin
      cmd_op = 2'b00; cmd_data = hold_data;
    end else begin
      cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_data = W'($urandom);
    end
    cyc = 1; got = 0;
    while (cyc <= M + 4 && !got) begin
      abort = (cyc == abort_at);
      if (op == 2'b00)      exp_q = (cyc >= 2) ? data : q0;
      else if (op == 2'b01) exp_q = (q0 + ((cyc - 1 < steps) ? cyc - 1 : steps)) % M;
      else if (op == 2'b10) exp_q = (q0 - ((cyc - 1 < steps) ? cyc - 1 : steps) + M) % M;
      else                  exp_q = q0;
      n_checks++;
      if (q !== W'(exp_q)) begin
        n_fail++; $display("FAIL q op=%0d cyc=%0d got %0d expected %0d", op, cyc, q, exp_q);
      end
      if (done === 1'b1) begin
        got = 1;
        n_checks++;
        if (cyc != exp_cyc) begin
          n_fail++; $display("FAIL done_cycle op=%0d got %0d expected %0d", op, cyc, exp_cyc);
        end
        n_checks++;
        if (done_wrapped !== exp_wrap) begin
          n_fail++; $display("FAIL done_wrapped op=%0d got %0b expected %0b", op, done_wrapped, exp_wrap);
        end
        n_checks++;
        if (done_aborted !== exp_abort) begin
          n_fail++; $display("FAIL done_aborted op=%0d got %0b expected %0b", op, done_aborted, exp_abort);
        end
      end else begin
        n_checks++;
        if (done_wrapped !== 1'b0 || done_aborted !== 1'b0 || busy !== 1'b1) begin
          n_fail++; $display("FAIL status_busy cyc=%0d got w=%0b a=%0b busy=%0b expected 0 0 1",
                             cyc, done_wrapped, done_aborted, busy);
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    abort = 1'b0;
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout op=%0d got no done expected cycle %0d", op, exp_cyc);
    end
    mq = fin_q;
    if (!hold) begin
      @(posedge clk); #1;
      n_checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || q !== W'(mq)) begin
        n_fail++; $display("FAIL idle_after ready=%0b busy=%0b done=%0b q=%0d expected 1 0 0 %0d",
                           cmd_ready, busy, done, q, mq);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0; abort = 1'b0;
    #1;
    n_checks++;
    if (q !== '0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        done_wrapped !== 1'b0 || done_aborted !== 1'b0) begin
      n_fail++; $display("FAIL reset_state q=%0d ready=%0b busy=%0b done=%0b w=%0b a=%0b expected 0 1 0 0 0 0",
                         q, cmd_ready, busy, done, done_wrapped, done_aborted);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    mq = 0;
  endtask

  task automatic test_directed();
    run_cmd(2'b00, 3, 0, 0, '0);
    run_cmd(2'b01, 5, 0, 0, '0);
    run_cmd(2'b00, 14, 0, 0, '0);
    run_cmd(2'b01, 1, 0, 0, '0);
    run_cmd(2'b10, 15, 0, 0, '0);
    run_cmd(2'b00, 0, 0, 0, '0);
    run_cmd(2'b01, 15, 7, 0, '0);   // abort raised in the cycle q==6
    run_cmd(2'b00, 9, 0, 0, '0);
    run_cmd(2'b01, 9, 0, 0, '0);
    run_cmd(2'b11, 4, 0, 0, '0);
    run_cmd(2'b10, 9, 1, 0, '0);    // abort coincident with target match
    run_cmd(2'b00, 5, 1, 0, '0);    // abort ignored by LOAD
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] hv;
    hv = W'($urandom_range(M - 1));
    run_cmd(2'b01, (mq + 6) % M, 0, 1, hv);
    @(posedge clk); #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || q !== W'(mq)) begin
      n_fail++; $display("FAIL held_valid_idle ready=%0b q=%0d expected 1 %0d", cmd_ready, q, mq);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b1 || q !== hv) begin
      n_fail++; $display("FAIL held_valid_load done=%0b q=%0d expected 1 %0d", done, q, hv);
    end
    mq = hv;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = W'((mq + M - 1) % M);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (q !== '0 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid q=%0d busy=%0b ready=%0b done=%0b expected 0 0 1 0",
                         q, busy, cmd_ready, done);
    end
    @(negedge clk); reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || q !== '0) begin
        n_fail++; $display("FAIL reset_mid_after done=%0b q=%0d expected 0 0", done, q);
      end
    end
    mq = 0;
  endtask

  task automatic test_random();
    logic [1:0] op;
    int ab;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      ab = ($urandom_range(3) == 0) ? $urandom_range(1, M) : 0;
      run_cmd(op, $urandom_range(M - 1), ab, 0, '0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
